// File: rtl/posit_wb_queue.sv
// posit_wb_queue: buffers posit results and issues them as byte-mode CCI-P c1 writes, tracking completions.
// Optional build macro POSIT_WB_BYPASS_EN: an input arriving at an empty FIFO goes straight to the output registers.
module posit_wb_queue #(
  parameter int DEPTH = 8,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_wr_addr,
  input  logic [39:0]  in_result,
  input  logic [41:0]  cfg_base_addr,
  input  logic [5:0]   cfg_granularity,
  input  logic         c1_almfull,
  output logic         c1_valid,
  output logic [41:0]  c1_addr,
  output logic [5:0]   c1_byte_start,
  output logic [5:0]   c1_byte_len,
  output logic [511:0] c1_data,
  input  logic         c1_rsp_valid,
  output logic [7:0]   outstanding,
  output logic         idle,
  output logic         rsp_underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

  logic [47:0]  mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         empty;
  logic         full;
  logic         issue_ok;
  logic         pop;
  logic         push;
  logic         bypass;
  logic         fire;
  logic [47:0]  src;
  logic [13:0]  off;
  logic [511:0] shifted;

  // Byte offset of a result slot from the buffer base; 63*255 still fits in 14 bits.
  function automatic logic [13:0] slot_offset(input logic [5:0] gran, input logic [7:0] slot);
    return 14'(gran) * 14'(slot);
  endfunction

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign issue_ok = !c1_almfull && (outstanding < MAX_OUT);
  assign pop      = !empty && issue_ok;

`ifdef POSIT_WB_BYPASS_EN
  assign bypass = empty && issue_ok && in_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push    = in_valid && in_ready && !bypass;
  assign fire    = pop || bypass;
  assign src     = pop ? mem[rd_ptr[AW-1:0]] : {in_wr_addr, in_result};
  assign off     = slot_offset(cfg_granularity, src[47:40]);
  assign shifted = 512'(src[39:0]) << {off[5:0], 3'b000};
  assign idle    = empty && (outstanding == 8'd0);

  // FIFO storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_wr_addr, in_result};
    end
  end

  // FIFO pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Registered c1 request, loaded from the FIFO head or the bypassed input.
  always_ff @(posedge clock) begin
    if (reset) begin
      c1_valid      <= 1'b0;
      c1_addr       <= 42'd0;
      c1_byte_start <= 6'd0;
      c1_byte_len   <= 6'd0;
      c1_data       <= 512'd0;
    end else begin
      c1_valid <= fire;
      if (fire) begin
        c1_addr       <= cfg_base_addr + {34'd0, off[13:6]};
        c1_byte_start <= off[5:0];
        c1_byte_len   <= cfg_granularity;
        c1_data       <= shifted;
      end
    end
  end

  // Outstanding-write credit counter; a lone response at zero is flagged instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding   <= 8'd0;
      rsp_underflow <= 1'b0;
    end else begin
      case ({fire, c1_rsp_valid})
        2'b10: outstanding <= outstanding + 8'd1;
        2'b01: begin
          if (outstanding == 8'd0) begin
            rsp_underflow <= 1'b1;
          end else begin
            outstanding <= outstanding - 8'd1;
          end
        end
        default: outstanding <= outstanding;
      endcase
    end
  end
endmodule
